// File: rtl/compression_pkg.sv
// Shared constants, state encoding and helpers for the compression datapath.
package compression_pkg;

  localparam int ACC_W      = 32;
  localparam int MAX_CODE_W = 18;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } packer_state_e;

  // Oversized length requests are treated as the widest legal code.
  function automatic logic [4:0] sat_bits(input logic [4:0] bits, input logic [4:0] max_w);
    return (bits > max_w) ? max_w : bits;
  endfunction

endpackage

// File: rtl/code_inserter.sv
// Bit-reverses a right-justified code of in_bits bits and ORs it into the
// accumulator just above the count bits already held.
module code_inserter #(
  parameter int ACC_W      = compression_pkg::ACC_W,
  parameter int MAX_CODE_W = compression_pkg::MAX_CODE_W,
  parameter int CNT_W      = $clog2(ACC_W + 1)
) (
  input  logic [ACC_W-1:0]      acc,
  input  logic [CNT_W-1:0]      count,
  input  logic [MAX_CODE_W-1:0] in_code,
  input  logic [4:0]            in_bits,
  output logic [ACC_W-1:0]      acc_next
);

  logic [MAX_CODE_W-1:0] rev_full_s;
  logic [MAX_CODE_W-1:0] rev_s;
  logic [4:0]            align_s;
  logic [ACC_W-1:0]      ins_s;

  // Full-width mirror puts in_code[in_bits-1] at rev_full_s[MAX-in_bits];
  // shifting right by MAX-in_bits drops the unused upper code bits.
  always_comb begin
    rev_full_s = '0;
    for (int i = 0; i < MAX_CODE_W; i++) begin
      rev_full_s[i] = in_code[MAX_CODE_W-1-i];
    end
    align_s  = 5'(MAX_CODE_W) - in_bits;
    rev_s    = rev_full_s >> align_s;
    ins_s    = {{(ACC_W-MAX_CODE_W){1'b0}}, rev_s} << count;
    acc_next = acc | ins_s;
  end

endmodule

// File: rtl/bit_packer.sv
// Packs variable-length codes (MSB-first) into a byte stream (LSB-first per
// byte), with a flush that zero-pads the final partial byte.
module bit_packer #(
  parameter int ACC_W      = compression_pkg::ACC_W,
  parameter int MAX_CODE_W = compression_pkg::MAX_CODE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAX_CODE_W-1:0] in_code,
  input  logic [4:0]            in_bits,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_byte,
  output logic                  out_last,
  output logic                  flush_done
);

  import compression_pkg::*;

  localparam int               CNT_W     = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] BYTE_CNT  = CNT_W'(BYTE_W);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ACC_W - MAX_CODE_W);

  packer_state_e    state_r;
  packer_state_e    state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] base_acc_s;
  logic [ACC_W-1:0] ins_acc_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] base_cnt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [4:0]       bits_sat_s;
  logic             in_hs_s;
  logic             out_hs_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             flush_done_r;
  logic             in_ready_nxt_s;
  logic             out_valid_nxt_s;
  logic             out_last_nxt_s;

  assign bits_sat_s = sat_bits(in_bits, 5'(MAX_CODE_W));

  // The inserter sees the post-shift accumulator, so a same-cycle input and
  // output handshake lands the new code at count-8.
  code_inserter #(
    .ACC_W      (ACC_W),
    .MAX_CODE_W (MAX_CODE_W),
    .CNT_W      (CNT_W)
  ) u_code_inserter (
    .acc      (base_acc_s),
    .count    (base_cnt_s),
    .in_code  (in_code),
    .in_bits  (bits_sat_s),
    .acc_next (ins_acc_s)
  );

  // Next accumulator, count, state and the values the output flops will hold.
  always_comb begin
    out_hs_s = out_valid_r && out_ready;
    in_hs_s  = in_valid && in_ready_r;

    if (out_hs_s) begin
      base_acc_s = acc_r >> BYTE_W;
      base_cnt_s = (count_r >= BYTE_CNT) ? (count_r - BYTE_CNT) : '0;
    end else begin
      base_acc_s = acc_r;
      base_cnt_s = count_r;
    end

    if (in_hs_s) begin
      acc_nxt_s = ins_acc_s;
      cnt_nxt_s = base_cnt_s + CNT_W'(bits_sat_s);
    end else begin
      acc_nxt_s = base_acc_s;
      cnt_nxt_s = base_cnt_s;
    end

    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (flush) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (cnt_nxt_s == '0) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      DONE:    state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase

    in_ready_nxt_s  = (state_nxt_s == RUN) && (cnt_nxt_s <= READY_MAX);
    out_valid_nxt_s = (cnt_nxt_s >= BYTE_CNT) ||
                      ((state_nxt_s == FLUSH) && (cnt_nxt_s != '0));
    out_last_nxt_s  = (state_nxt_s == FLUSH) && out_valid_nxt_s &&
                      (cnt_nxt_s <= BYTE_CNT);
  end

  // Datapath, FSM state and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r        <= '0;
      count_r      <= '0;
      state_r      <= RUN;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      acc_r        <= acc_nxt_s;
      count_r      <= cnt_nxt_s;
      state_r      <= state_nxt_s;
      in_ready_r   <= in_ready_nxt_s;
      out_valid_r  <= out_valid_nxt_s;
      out_last_r   <= out_last_nxt_s;
      flush_done_r <= (state_nxt_s == DONE);
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign flush_done = flush_done_r;
  assign out_byte   = acc_r[7:0];

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset, named clk and rst.
REQ-002 SHALL have these ports, one per line below (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  in_valid  in  1  code word present.
  in_ready  out  1  packer can accept a word this cycle.
  in_code  in  18  code word, right-justified.
  in_bits  in  5  number of valid bits in in_code, 0..18.
  flush  in  1  drain request; pads the final partial byte with zeros.
  out_valid  out  1  out_byte valid.
  out_ready  in  1  consumer accepts out_byte.
  out_byte  out  8  packed stream byte.
  out_last  out  1  marks the final byte of a flush.
  flush_done  out  1  one-cycle pulse when a flush has completed.
REQ-003 SHALL use these parameters (name, default, meaning): ACC_W, 32, accumulator width; MAX_CODE_W, 18, maximum code width.

Function
REQ-004 SHALL hold an ACC_W-bit accumulator acc and a 6-bit count (0..32) of valid bits.
REQ-005 SHALL perform an input handshake when in_valid && in_ready in the same cycle.
REQ-006 SHALL drive in_ready = (state==RUN) && (count <= ACC_W-MAX_CODE_W), i.e. count <= 14.
REQ-007 SHALL serialize each code MSB-first: in_code[in_bits-1] is the first stream bit.
REQ-008 SHALL place stream bits LSB-first into bytes: the first bit of the stream goes to out_byte[0].
REQ-009 SHALL insert an accepted word as acc[count+i] = in_code[in_bits-1-i] for i = 0..in_bits-1, then set count += in_bits.
REQ-010 SHALL treat in_bits = 0 as an accepted no-op.
REQ-011 SHALL saturate in_bits values 19..31 to 18.
REQ-012 SHALL drive out_byte = acc[7:0].
REQ-013 SHALL assert out_valid when count >= 8, or when state==FLUSH && count > 0.
REQ-014 SHALL, on an output handshake, shift acc right by 8, zero-fill the vacated bits, and set count = max(count-8, 0).
REQ-015 SHALL handle a simultaneous input and output handshake in one cycle: shift first, then insert at position count-8; no bit is lost or duplicated.
REQ-016 SHALL register both acc and count: a word accepted in cycle N is visible on out_byte/out_valid in cycle N+1. Out-to-out latency is 0; no combinational path runs from in_* to out_*.
REQ-017 SHALL implement three states:
  RUN: normal operation.
  FLUSH: in_ready = 0; drain all bits. A partial last byte is zero-padded in bits [7:count].
  DONE: flush_done = 1 for one cycle, then return to RUN.
REQ-018 SHALL move RUN -> FLUSH on flush = 1. A word handshaken in the same cycle is included in the flush.
REQ-019 SHALL move FLUSH -> DONE on the handshake in which count becomes 0. Flush with count = 0 goes directly FLUSH -> DONE on the next cycle, and no byte is emitted.
REQ-020 SHALL assert out_last only in FLUSH, when out_valid = 1 and count <= 8.
REQ-021 SHALL ignore flush while in FLUSH or DONE.
REQ-022 SHALL hold out_byte, out_valid and out_last stable while out_valid && !out_ready.

Reset
REQ-023 SHALL on rst set acc = 0, count = 0, state = RUN, out_valid = 0, out_last = 0 and flush_done = 0. in_ready = 1 in the first cycle after reset.
REQ-024 SHALL discard all buffered bits when rst is asserted mid-flush or mid-stream, with no further output.

Structure
REQ-025 SHALL define ACC_W, MAX_CODE_W, BYTE_W = 8 and the state enum {RUN, FLUSH, DONE} in a shared package, compression_pkg.
REQ-026 SHALL place the variable-width bit reversal plus shift-insert in one combinational sub-module, code_inserter (inputs: acc, count, in_code, in_bits; output: next acc). All other logic stays in bit_packer.

Verification
REQ-027 SHALL pass: code 0x001/7 bits, then code 0xC5/8 bits, then flush -> bytes 0xC0, then 0x51 with out_last = 1, then flush_done pulse.
REQ-028 SHALL pass: out_ready = 0, code 0x3FFFF/18 bits -> in_ready = 0 while count = 18. Then set out_ready = 1 -> bytes 0xFF, 0xFF; in_ready reasserts once count = 2.
REQ-029 SHALL pass: out_ready = 1 throughout, 8-bit code 0xA5 every cycle -> out_byte = 0xA5 every cycle from the second cycle onward. Input handshakes occur in each cycle while count <= 14, and no bit is lost.
REQ-030 SHALL pass: flush with count = 0 -> no out_valid; flush_done pulses two cycles after flush.
REQ-031 SHALL pass: 3-bit code 0b101 then flush, with rst asserted while out_valid = 1 and out_ready = 0 -> after reset out_valid = 0, count = 0, state = RUN.
REQ-032 SHALL pass: in_bits = 0 with in_valid = 1 -> handshake occurs, count is unchanged and no byte is emitted.
